scarv_axi_bridge: RTL and testbench

Parametrised, fully registered bridge from the native PicoRV32-style memory interface to an AXI4-lite master. It generalises address and data width and adds per-transfer request capture. It tracks the AW and W handshakes independently and gates the response channels. It also reports AXI error responses and offers an optional watchdog timeout. It sits between the core's memory port and the SoC interconnect, one instance per memory port.

---
 rtl/scarv_axi_pkg.sv | 21 ++
 rtl/scarv_axi_watchdog.sv | 40 ++++
 rtl/scarv_axi_bridge.sv | 223 ++++++++++++++++++++++
 tb/tb_scarv_axi_bridge.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scarv_axi_pkg.sv
// Shared constants and state encoding for the native-to-AXI4-lite bridge.
package scarv_axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] PROT_DATA  = 3'b000;
  localparam logic [2:0] PROT_INSTR = 3'b100;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_REQ,
    S_WR_RESP,
    S_RD_REQ,
    S_RD_RESP,
    S_DONE
  } state_t;

endpackage

// File: rtl/scarv_axi_watchdog.sv
// Saturating wait-cycle counter; expire flags the last allowed cycle.
// With TIMEOUT=0 the counter never advances and expire is tied low.
module scarv_axi_watchdog #(
  parameter int TIMEOUT = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  logic [CNT_W-1:0] count_q, count_d;

  // Clear wins over increment; increment stops at all-ones instead of wrapping.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (TIMEOUT > 0) && (count_q != CNT_MAX)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire = (TIMEOUT > 0) && (count_q == CNT_LAST);

endmodule

// File: rtl/scarv_axi_bridge.sv
// PicoRV32-style native memory port to AXI4-lite master bridge.
// One request in flight; every AXI and native output comes from a flop.
module scarv_axi_bridge
  import scarv_axi_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 0
) (
  input  logic                clk,
  input  logic                reset,
  output logic                mem_axi_awvalid,
  input  logic                mem_axi_awready,
  output logic [ADDR_W-1:0]   mem_axi_awaddr,
  output logic [2:0]          mem_axi_awprot,
  output logic                mem_axi_wvalid,
  input  logic                mem_axi_wready,
  output logic [DATA_W-1:0]   mem_axi_wdata,
  output logic [DATA_W/8-1:0] mem_axi_wstrb,
  input  logic                mem_axi_bvalid,
  output logic                mem_axi_bready,
  input  logic [1:0]          mem_axi_bresp,
  output logic                mem_axi_arvalid,
  input  logic                mem_axi_arready,
  output logic [ADDR_W-1:0]   mem_axi_araddr,
  output logic [2:0]          mem_axi_arprot,
  input  logic                mem_axi_rvalid,
  output logic                mem_axi_rready,
  input  logic [DATA_W-1:0]   mem_axi_rdata,
  input  logic [1:0]          mem_axi_rresp,
  input  logic                mem_valid,
  input  logic                mem_instr,
  output logic                mem_ready,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W/8-1:0] mem_wstrb,
  output logic [DATA_W-1:0]   mem_rdata,
  output logic                mem_error
);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
  logic [2:0]          arprot_q, arprot_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                awvalid_q, awvalid_d;
  logic                wvalid_q, wvalid_d;
  logic                arvalid_q, arvalid_d;
  logic                bready_q, bready_d;
  logic                rready_q, rready_d;
  logic                aw_ack_q, aw_ack_d;
  logic                w_ack_q, w_ack_d;
  logic                ready_q, ready_d;
  logic                error_q, error_d;

  logic aw_done, w_done, axi_wait, wd_expire, timeout;

  // AW and W are acknowledged independently; either may land first.
  assign aw_done  = aw_ack_q | (awvalid_q & mem_axi_awready);
  assign w_done   = w_ack_q  | (wvalid_q  & mem_axi_wready);
  assign axi_wait = (state_q == S_WR_REQ)  || (state_q == S_WR_RESP) ||
                    (state_q == S_RD_REQ)  || (state_q == S_RD_RESP);
  assign timeout  = wd_expire & axi_wait;

  scarv_axi_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clr    (state_d != state_q),
    .en     (axi_wait),
    .expire (wd_expire)
  );

  // Next-state and next-output logic; outputs are precomputed for the next cycle.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    arprot_d  = arprot_q;
    rdata_d   = rdata_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    arvalid_d = arvalid_q;
    bready_d  = 1'b0;
    rready_d  = 1'b0;
    aw_ack_d  = aw_ack_q;
    w_ack_d   = w_ack_q;
    ready_d   = 1'b0;
    error_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (mem_valid) begin
          addr_d   = mem_addr;
          wdata_d  = mem_wdata;
          wstrb_d  = mem_wstrb;
          arprot_d = mem_instr ? PROT_INSTR : PROT_DATA;
          if (|mem_wstrb) begin
            state_d   = S_WR_REQ;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_ack_d  = 1'b0;
            w_ack_d   = 1'b0;
          end else begin
            state_d   = S_RD_REQ;
            arvalid_d = 1'b1;
          end
        end
      end
      S_WR_REQ: begin
        aw_ack_d  = aw_done;
        w_ack_d   = w_done;
        awvalid_d = ~aw_done;
        wvalid_d  = ~w_done;
        if (aw_done && w_done) begin
          state_d  = S_WR_RESP;
          bready_d = 1'b1;
        end
      end
      S_WR_RESP: begin
        if (mem_axi_bvalid) begin
          state_d = S_DONE;
          ready_d = 1'b1;
          error_d = (mem_axi_bresp != RESP_OKAY);
        end else begin
          bready_d = 1'b1;
        end
      end
      S_RD_REQ: begin
        if (mem_axi_arready) begin
          state_d   = S_RD_RESP;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end
      end
      S_RD_RESP: begin
        if (mem_axi_rvalid) begin
          state_d = S_DONE;
          ready_d = 1'b1;
          error_d = (mem_axi_rresp != RESP_OKAY);
          rdata_d = mem_axi_rdata;
        end else begin
          rready_d = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Watchdog expiry abandons the transfer; the interconnect needs a reset after this.
    if (timeout) begin
      state_d   = S_DONE;
      awvalid_d = 1'b0;
      wvalid_d  = 1'b0;
      arvalid_d = 1'b0;
      bready_d  = 1'b0;
      rready_d  = 1'b0;
      ready_d   = 1'b1;
      error_d   = 1'b1;
      if ((state_q == S_RD_REQ) || (state_q == S_RD_RESP)) begin
        rdata_d = '0;
      end
    end
  end

  // FSM, capture and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      arprot_q  <= '0;
      rdata_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      bready_q  <= 1'b0;
      rready_q  <= 1'b0;
      aw_ack_q  <= 1'b0;
      w_ack_q   <= 1'b0;
      ready_q   <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      arprot_q  <= arprot_d;
      rdata_q   <= rdata_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      arvalid_q <= arvalid_d;
      bready_q  <= bready_d;
      rready_q  <= rready_d;
      aw_ack_q  <= aw_ack_d;
      w_ack_q   <= w_ack_d;
      ready_q   <= ready_d;
      error_q   <= error_d;
    end
  end

  assign mem_axi_awvalid = awvalid_q;
  assign mem_axi_awaddr  = addr_q;
  assign mem_axi_awprot  = PROT_DATA;
  assign mem_axi_wvalid  = wvalid_q;
  assign mem_axi_wdata   = wdata_q;
  assign mem_axi_wstrb   = wstrb_q;
  assign mem_axi_bready  = bready_q;
  assign mem_axi_arvalid = arvalid_q;
  assign mem_axi_araddr  = addr_q;
  assign mem_axi_arprot  = arprot_q;
  assign mem_axi_rready  = rready_q;
  assign mem_ready       = ready_q;
  assign mem_error       = error_q;
  assign mem_rdata       = rdata_q;

endmodule

// File: tb/tb_scarv_axi_bridge.sv
// Bench for scarv_axi_bridge: configurable AXI slave, scoreboard of native completions.
module tb_scarv_axi_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_axi_awvalid, mem_axi_awready;
  logic [31:0] mem_axi_awaddr;
  logic [2:0]  mem_axi_awprot;
  logic        mem_axi_wvalid, mem_axi_wready;
  logic [31:0] mem_axi_wdata;
  logic [3:0]  mem_axi_wstrb;
  logic        mem_axi_bvalid, mem_axi_bready;
  logic [1:0]  mem_axi_bresp;
  logic        mem_axi_arvalid, mem_axi_arready;
  logic [31:0] mem_axi_araddr;
  logic [2:0]  mem_axi_arprot;
  logic        mem_axi_rvalid, mem_axi_rready;
  logic [31:0] mem_axi_rdata;
  logic [1:0]  mem_axi_rresp;
  logic        mem_valid, mem_instr, mem_ready, mem_error;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  scarv_axi_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .mem_axi_awvalid(mem_axi_awvalid), .mem_axi_awready(mem_axi_awready),
    .mem_axi_awaddr(mem_axi_awaddr), .mem_axi_awprot(mem_axi_awprot),
    .mem_axi_wvalid(mem_axi_wvalid), .mem_axi_wready(mem_axi_wready),
    .mem_axi_wdata(mem_axi_wdata), .mem_axi_wstrb(mem_axi_wstrb),
    .mem_axi_bvalid(mem_axi_bvalid), .mem_axi_bready(mem_axi_bready),
    .mem_axi_bresp(mem_axi_bresp),
    .mem_axi_arvalid(mem_axi_arvalid), .mem_axi_arready(mem_axi_arready),
    .mem_axi_araddr(mem_axi_araddr), .mem_axi_arprot(mem_axi_arprot),
    .mem_axi_rvalid(mem_axi_rvalid), .mem_axi_rready(mem_axi_rready),
    .mem_axi_rdata(mem_axi_rdata), .mem_axi_rresp(mem_axi_rresp),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata), .mem_error(mem_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rd;
    logic [31:0] rdata;
    bit          err;
  } exp_t;

  exp_t sb[$];
  int   n_total = 0;
  int   n_bad   = 0;

  // Slave knobs, written by the main sequence only.
  int          aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0, r_dly = 0;
  logic [1:0]  sl_bresp = 2'b00, sl_rresp = 2'b00;
  logic [31:0] sl_rdata = 32'h0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // AXI slave: drives at negedge; handshakes are inferred from last negedge's values.
  int   aw_n, w_n, ar_n, b_n, r_n;
  logic aw_got, w_got, ar_got;
  logic pv_aw, pv_w, pv_ar, pv_bready, pv_rready;
  initial begin
    mem_axi_awready = 0; mem_axi_wready = 0; mem_axi_arready = 0;
    mem_axi_bvalid = 0; mem_axi_rvalid = 0;
    mem_axi_bresp = 0; mem_axi_rresp = 0; mem_axi_rdata = 0;
    aw_n = 0; w_n = 0; ar_n = 0; b_n = 0; r_n = 0;
    aw_got = 0; w_got = 0; ar_got = 0;
    pv_aw = 0; pv_w = 0; pv_ar = 0; pv_bready = 0; pv_rready = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        mem_axi_awready = 0; mem_axi_wready = 0; mem_axi_arready = 0;
        mem_axi_bvalid = 0; mem_axi_rvalid = 0;
        aw_n = 0; w_n = 0; ar_n = 0; b_n = 0; r_n = 0;
        aw_got = 0; w_got = 0; ar_got = 0;
        pv_aw = 0; pv_w = 0; pv_ar = 0; pv_bready = 0; pv_rready = 0;
      end else begin
        if (pv_aw && mem_axi_awready) aw_got = 1;
        if (pv_w  && mem_axi_wready)  w_got  = 1;
        if (pv_ar && mem_axi_arready) ar_got = 1;
        if (mem_axi_bvalid && pv_bready) mem_axi_bvalid = 0;
        if (mem_axi_rvalid && pv_rready) mem_axi_rvalid = 0;
        if (mem_axi_awvalid) begin mem_axi_awready = (aw_n >= aw_dly); aw_n++; end
        else begin mem_axi_awready = 0; aw_n = 0; end
        if (mem_axi_wvalid) begin mem_axi_wready = (w_n >= w_dly); w_n++; end
        else begin mem_axi_wready = 0; w_n = 0; end
        if (mem_axi_arvalid) begin mem_axi_arready = (ar_n >= ar_dly); ar_n++; end
        else begin mem_axi_arready = 0; ar_n = 0; end
        if (aw_got && w_got && !mem_axi_bvalid) begin
          if (b_n >= b_dly) begin
            mem_axi_bvalid = 1; mem_axi_bresp = sl_bresp;
            aw_got = 0; w_got = 0; b_n = 0;
          end else b_n++;
        end
        if (ar_got && !mem_axi_rvalid) begin
          if (r_n >= r_dly) begin
            mem_axi_rvalid = 1; mem_axi_rresp = sl_rresp; mem_axi_rdata = sl_rdata;
            ar_got = 0; r_n = 0;
          end else r_n++;
        end
        pv_aw = mem_axi_awvalid; pv_w = mem_axi_wvalid; pv_ar = mem_axi_arvalid;
        pv_bready = mem_axi_bready; pv_rready = mem_axi_rready;
      end
    end
  end

  // Scoreboard: every mem_ready pulse must match the oldest outstanding request.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mem_ready === 1'b1) begin
        chk("ready_expected", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("sb_error", mem_error, e.err);
          if (e.rd) chk("sb_rdata", mem_rdata, e.rdata);
        end
      end
    end
  end

  // Global time limit.
  initial begin
    #100000;
    $display("FAIL global_timeout got=%0d exp=%0d", n_total, 0);
    $fatal(1, "time limit");
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                       input logic ins, input logic [31:0] erd, input bit eerr);
    exp_t e;
    mem_valid = 1; mem_addr = a; mem_wdata = wd; mem_wstrb = ws; mem_instr = ins;
    e.rd = (ws == 4'h0); e.rdata = erd; e.err = eerr;
    sb.push_back(e);
  endtask

  task automatic idle();
    mem_valid = 0; mem_addr = 32'h0; mem_wdata = 32'h0; mem_wstrb = 4'h0; mem_instr = 0;
  endtask

  task automatic wait_ready(input string tag, input int maxc, output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (mem_ready !== 1'b1 && k < maxc);
    chk({tag, "_ready_seen"}, mem_ready, 1);
  endtask

  int k, cnt_a, cnt_b, bad;

  initial begin
    reset = 1;
    idle();
    repeat (2) @(negedge clk);
    chk("rst_awvalid", mem_axi_awvalid, 0);
    chk("rst_wvalid", mem_axi_wvalid, 0);
    chk("rst_arvalid", mem_axi_arvalid, 0);
    chk("rst_bready", mem_axi_bready, 0);
    chk("rst_rready", mem_axi_rready, 0);
    chk("rst_mem_ready", mem_ready, 0);
    chk("rst_mem_error", mem_error, 0);
    chk("rst_rdata", mem_rdata, 0);
    chk("rst_addr", mem_axi_araddr, 0);
    chk("rst_arprot", mem_axi_arprot, 0);
    chk("rst_wstrb", mem_axi_wstrb, 0);
    reset = 0;

    // Zero-wait read.
    @(negedge clk);
    sl_rdata = 32'hDEADBEEF;
    issue(32'h1000, 32'h0, 4'h0, 0, 32'hDEADBEEF, 0);
    @(negedge clk);
    chk("rd0_arvalid_p1", mem_axi_arvalid, 1);
    chk("rd0_araddr", mem_axi_araddr, 32'h1000);
    chk("rd0_arprot", mem_axi_arprot, 3'b000);
    wait_ready("rd0", 20, k);
    chk("rd0_latency", k + 1, 3);
    idle();

    // Instruction fetch with arready held off for 4 cycles.
    @(negedge clk);
    ar_dly = 4; sl_rdata = 32'hCAFEF00D;
    issue(32'h1004, 32'h0, 4'h0, 1, 32'hCAFEF00D, 0);
    k = 0; cnt_a = 0; bad = 0;
    do begin
      @(negedge clk);
      k++;
      if (k == 1) mem_addr = 32'hFFFF_FFFC;
      if (mem_axi_arvalid) begin
        cnt_a++;
        if (mem_axi_araddr !== 32'h1004 || mem_axi_arprot !== 3'b100) bad++;
      end
    end while (mem_ready !== 1'b1 && k < 40);
    chk("if_ready_seen", mem_ready, 1);
    chk("if_latency", k, 7);
    chk("if_ar_hold", cnt_a, 5);
    chk("if_ar_stable", bad, 0);
    idle(); ar_dly = 0;

    // Write: W accepted 2 cycles before AW, B two cycles late.
    @(negedge clk);
    aw_dly = 2; b_dly = 2; sl_bresp = 2'b00;
    issue(32'h2004, 32'h12345678, 4'hF, 0, 32'h0, 0);
    k = 0; cnt_a = 0; cnt_b = 0; bad = 0;
    do begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        chk("wr_awaddr", mem_axi_awaddr, 32'h2004);
        chk("wr_wdata", mem_axi_wdata, 32'h12345678);
        chk("wr_wstrb", mem_axi_wstrb, 4'hF);
        chk("wr_awprot", mem_axi_awprot, 3'b000);
      end
      if (mem_axi_awvalid && !mem_axi_wvalid) cnt_a++;
      if (mem_axi_bready) cnt_b++;
      if (mem_axi_bready && (mem_axi_awvalid || mem_axi_wvalid)) bad++;
    end while (mem_ready !== 1'b1 && k < 40);
    chk("wr_ready_seen", mem_ready, 1);
    chk("wr_latency", k, 7);
    chk("wr_aw_only_cycles", cnt_a, 2);
    chk("wr_bready_cycles", cnt_b, 3);
    chk("wr_bready_overlap", bad, 0);
    chk("wr_rdata_kept", mem_rdata, 32'hCAFEF00D);
    idle(); aw_dly = 0; b_dly = 0;

    // Same-cycle AW/W with SLVERR, then a back-to-back read.
    @(negedge clk);
    sl_bresp = 2'b10;
    issue(32'h2008, 32'hA5A5A5A5, 4'h3, 0, 32'h0, 1);
    wait_ready("wr_err", 20, k);
    chk("wr_err_latency", k, 3);
    sl_rdata = 32'h0BADC0DE;
    issue(32'h3000, 32'h0, 4'h0, 0, 32'h0BADC0DE, 0);
    k = 0; bad = 0;
    do begin
      @(negedge clk);
      k++;
      if (k == 2 && mem_axi_araddr !== 32'h3000) bad++;
    end while (mem_ready !== 1'b1 && k < 20);
    chk("b2b_ready_seen", mem_ready, 1);
    chk("b2b_latency", k, 4);
    chk("b2b_araddr", bad, 0);
    idle(); sl_bresp = 2'b00;

    // Watchdog: arready never comes.
    @(negedge clk);
    ar_dly = 1000;
    issue(32'h4000, 32'h0, 4'h0, 0, 32'h0, 1);
    k = 0; cnt_a = 0;
    do begin
      @(negedge clk);
      k++;
      if (mem_axi_arvalid) cnt_a++;
    end while (mem_ready !== 1'b1 && k < 40);
    chk("to_ready_seen", mem_ready, 1);
    chk("to_latency", k, 9);
    chk("to_ar_cycles", cnt_a, 8);
    chk("to_arvalid_low", mem_axi_arvalid, 0);
    idle(); ar_dly = 0;

    // Read with DECERR and a delayed R beat.
    @(negedge clk);
    r_dly = 1; sl_rresp = 2'b11; sl_rdata = 32'h55AA55AA;
    issue(32'h5000, 32'h0, 4'h0, 0, 32'h55AA55AA, 1);
    wait_ready("decerr", 20, k);
    chk("decerr_latency", k, 4);
    idle(); r_dly = 0; sl_rresp = 2'b00;

    // Reset in RD_RESP while rvalid is presented.
    @(negedge clk);
    sl_rdata = 32'h77777777;
    issue(32'h5004, 32'h0, 4'h0, 0, 32'h77777777, 0);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (mem_axi_rready !== 1'b1 && k < 20);
    chk("rst_mid_rready_seen", mem_axi_rready, 1);
    #2;
    reset = 1;
    idle();
    #1;
    chk("rst_mid_rready", mem_axi_rready, 0);
    chk("rst_mid_arvalid", mem_axi_arvalid, 0);
    chk("rst_mid_awvalid", mem_axi_awvalid, 0);
    chk("rst_mid_wvalid", mem_axi_wvalid, 0);
    chk("rst_mid_mem_ready", mem_ready, 0);
    chk("rst_mid_rdata", mem_rdata, 0);
    sb.delete();
    @(negedge clk);
    #2;
    reset = 0;
    cnt_a = 0;
    repeat (3) begin
      @(negedge clk);
      if (mem_ready) cnt_a++;
    end
    chk("rst_mid_no_ready", cnt_a, 0);
    sl_rdata = 32'h600DF00D;
    issue(32'h6000, 32'h0, 4'h0, 0, 32'h600DF00D, 0);
    wait_ready("post_rst", 20, k);
    chk("post_rst_latency", k, 3);
    idle();

    repeat (3) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
